// File: rtl/score_display_if.sv
// Bundle between the score tracker (master) and the seven-segment display block (slave).
interface score_display_if;
  logic [6:0] dispScore;
  logic       isGameComplete;
  logic [6:0] ss2;
  logic [6:0] ss1;
  logic [6:0] ss0;
  logic       busy;

  modport master (
    output dispScore,
    output isGameComplete,
    input  ss2,
    input  ss1,
    input  ss0,
    input  busy
  );

  modport slave (
    input  dispScore,
    input  isGameComplete,
    output ss2,
    output ss1,
    output ss0,
    output busy
  );
endinterface

// File: rtl/score_display.sv
// Three-digit seven-segment score display.
// A new binary score is converted to BCD by a sequential double-dabble
// (7 shift-add-3 steps) and then latched into the digit registers.
// Leading zeros are blanked, and the whole display flashes while the
// game is complete.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | digits stable; watching for dispScore != last converted score
// CONV  | one shift-add-3 step per clock, 7 steps in total
// LOAD  | copy BCD nibbles into the digit registers, drop busy
module score_display #(
  parameter int FLASH_CYCLES = 6_000_000
) (
  input  logic           clk,
  input  logic           rst,
  score_display_if.slave disp_if
);

  localparam int CW = (FLASH_CYCLES > 2) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  last_q, last_d;
  logic [18:0] shift_q, shift_d;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        busy_q, busy_d;

  logic [CW-1:0] flash_cnt_q, flash_cnt_d;
  logic          visible_q, visible_d;
  // Set once the first complete-edge has been seen; that edge only arms
  // the flash so the display stays on for a full half-period first.
  logic          armed_q, armed_d;

  // One double-dabble step: correct each BCD nibble, then shift left.
  function automatic logic [18:0] dabble_step(input logic [18:0] s);
    logic [18:0] t;
    t = s;
    if (t[18:15] >= 4'd5) t[18:15] = t[18:15] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
    return {t[17:0], 1'b0};
  endfunction

  // Segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 7'd0;
      shift_q     <= 19'd0;
      iter_q      <= 3'd0;
      hund_q      <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      busy_q      <= 1'b0;
      flash_cnt_q <= '0;
      visible_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      iter_q      <= iter_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      busy_q      <= busy_d;
      flash_cnt_q <= flash_cnt_d;
      visible_q   <= visible_d;
      armed_q     <= armed_d;
    end
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shift_d = shift_q;
    iter_d  = iter_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (disp_if.dispScore != last_q) begin
          last_d  = disp_if.dispScore;
          shift_d = {12'd0, disp_if.dispScore};
          iter_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        shift_d = dabble_step(shift_q);
        if (iter_q == 3'd6) begin
          state_d = LOAD;
        end else begin
          iter_d = iter_q + 3'd1;
        end
      end
      LOAD: begin
        hund_d  = shift_q[18:15];
        tens_d  = shift_q[14:11];
        ones_d  = shift_q[10:7];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Flash timer: idle at 0/visible while not complete, toggles every FLASH_CYCLES.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    visible_d   = visible_q;
    armed_d     = armed_q;
    if (!disp_if.isGameComplete) begin
      flash_cnt_d = '0;
      visible_d   = 1'b1;
      armed_d     = 1'b0;
    end else if (!armed_q) begin
      flash_cnt_d = '0;
      visible_d   = 1'b1;
      armed_d     = 1'b1;
    end else if (flash_cnt_q == CNT_LAST) begin
      flash_cnt_d = '0;
      visible_d   = ~visible_q;
    end else begin
      flash_cnt_d = flash_cnt_q + 1'b1;
    end
  end

  // Segment drive with leading-zero blanking and flash gating.
  always_comb begin
    disp_if.ss2  = 7'h00;
    disp_if.ss1  = 7'h00;
    disp_if.ss0  = 7'h00;
    disp_if.busy = busy_q;
    if (visible_q) begin
      if (hund_q != 4'd0) disp_if.ss2 = seg7(hund_q);
      if ((hund_q != 4'd0) || (tens_q != 4'd0)) disp_if.ss1 = seg7(tens_q);
      disp_if.ss0 = seg7(ones_q);
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short flash period.
module tb_score_display;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  score_display_if sif ();

  score_display #(.FLASH_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_if (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] score;
    logic [6:0] e2;
    logic [6:0] e1;
    logic [6:0] e0;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_digits(input string tag, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, ".ss2"}, sif.ss2, e2);
    chk({tag, ".ss1"}, sif.ss1, e1);
    chk({tag, ".ss0"}, sif.ss0, e0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{7'd7,   7'h00, 7'h00, 7'h07};
    vecs[1]  = '{7'd127, 7'h06, 7'h5B, 7'h07};
    vecs[2]  = '{7'd50,  7'h00, 7'h6D, 7'h3F};
    vecs[3]  = '{7'd0,   7'h00, 7'h00, 7'h3F};
    vecs[4]  = '{7'd100, 7'h06, 7'h3F, 7'h3F};
    vecs[5]  = '{7'd105, 7'h06, 7'h3F, 7'h6D};
    vecs[6]  = '{7'd10,  7'h00, 7'h06, 7'h3F};
    vecs[7]  = '{7'd99,  7'h00, 7'h6F, 7'h6F};
    vecs[8]  = '{7'd64,  7'h00, 7'h7D, 7'h66};
    vecs[9]  = '{7'd88,  7'h00, 7'h7F, 7'h7F};
    vecs[10] = '{7'd1,   7'h00, 7'h00, 7'h06};

    // Reset held for two edges.
    rst = 1'b1;
    sif.dispScore = 7'd0;
    sif.isGameComplete = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_digits("reset", 7'h00, 7'h00, 7'h3F);
    chk("reset.busy", {6'd0, sif.busy}, 7'd0);

    // Table of conversions: busy high after E0..E7, result after E8.
    foreach (vecs[i]) begin
      sif.dispScore = vecs[i].score;
      tick();
      chk($sformatf("v%0d.busy_e0", i), {6'd0, sif.busy}, 7'd1);
      for (int k = 0; k < 7; k++) tick();
      chk($sformatf("v%0d.busy_e7", i), {6'd0, sif.busy}, 7'd1);
      tick();
      chk($sformatf("v%0d.busy_e8", i), {6'd0, sif.busy}, 7'd0);
      chk_digits($sformatf("v%0d", i), vecs[i].e2, vecs[i].e1, vecs[i].e0);
    end

    // Score changes mid-conversion: first value finishes, then the final value.
    sif.dispScore = 7'd12;
    tick();
    tick();
    sif.dispScore = 7'd34;
    for (int k = 0; k < 7; k++) tick();
    chk("mid.busy_e8", {6'd0, sif.busy}, 7'd0);
    chk_digits("mid12", 7'h00, 7'h06, 7'h5B);
    tick();
    chk("mid.busy_e9", {6'd0, sif.busy}, 7'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("mid.busy_done", {6'd0, sif.busy}, 7'd0);
    chk_digits("mid34", 7'h00, 7'h4F, 7'h66);

    // Flash with score 9: on 4 edges, off 4, on 4; drop restores steady.
    sif.dispScore = 7'd9;
    for (int k = 0; k < 9; k++) tick();
    chk_digits("nine", 7'h00, 7'h00, 7'h6F);
    sif.isGameComplete = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("flash%0d.ss0", k), sif.ss0,
          ((k <= 4) || (k >= 9)) ? 7'h6F : 7'h00);
    end
    for (int k = 0; k < 4; k++) tick();
    chk("flash_off.ss0", sif.ss0, 7'h00);
    sif.isGameComplete = 1'b0;
    tick();
    chk("flash_drop.ss0", sif.ss0, 7'h6F);
    for (int k = 0; k < 5; k++) tick();
    chk("flash_steady.ss0", sif.ss0, 7'h6F);

    // Reset during conversion of 99 abandons it.
    sif.dispScore = 7'd99;
    tick();
    tick();
    tick();
    chk("rstconv.busy_pre", {6'd0, sif.busy}, 7'd1);
    rst = 1'b1;
    sif.dispScore = 7'd0;
    tick();
    chk("rstconv.busy", {6'd0, sif.busy}, 7'd0);
    chk_digits("rstconv", 7'h00, 7'h00, 7'h3F);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("rstconv.idle_busy", {6'd0, sif.busy}, 7'd0);
    chk_digits("rstconv_idle", 7'h00, 7'h00, 7'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
